div_seq_n: RTL and testbench
============================

DIV_SEQ_N -- requirements
Module: div_seq_n

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/quotient/remainder width (legal 4..64).
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port clear  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 SHALL have port a_dividend  input  WIDTH  dividend; sampled with start.
REQ-007 SHALL have port b_divisor  input  WIDTH  divisor; sampled with start.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-010 SHALL have port div_by_zero  output  1  set with done when the sampled divisor was 0.
REQ-011 SHALL have port c_quotient_and_remainder  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.

Function
REQ-012 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: start=1 at an edge SHALL latch operands and mode, set busy, go to CALC (divisor nonzero) or FIX (divisor zero).
REQ-014 Signed mode: SHALL divide magnitudes |a|,|b|, held as WIDTH-bit unsigned values.
REQ-015 CALC SHALL perform one non-restoring iteration per cycle (shift {A,Q} left; subtract divisor if A>=0 else add; Q[0]=~A sign), A being WIDTH+1 bits, for exactly WIDTH cycles, counted by an internal iteration counter.
REQ-016 FIX SHALL add the divisor back if A<0, then negate quotient when signed_mode and sign(a)^sign(b), negate remainder when signed_mode and sign(a); register result.
REQ-017 DONE SHALL assert done for exactly one cycle, clear busy, and return to IDLE on the next edge.
REQ-018 Latency: done SHALL be high in the cycle following edge k+WIDTH+2, where k is the edge sampling start (34 cycles at WIDTH=32).
REQ-019 Divide-by-zero: SHALL skip CALC; quotient = all ones, remainder = a_dividend unmodified (both modes), div_by_zero=1; done after edge k+2.
REQ-020 Signed overflow (a = most negative, b = -1): quotient SHALL equal most negative value, remainder 0, div_by_zero=0.
REQ-021 Remainder sign SHALL match dividend sign (truncating division); |remainder| < |divisor|.
REQ-022 c_quotient_and_remainder and div_by_zero SHALL hold the last result until the next FIX completes; they SHALL NOT change during CALC.
REQ-023 start while busy=1 (CALC, FIX, DONE) SHALL be ignored; operand/mode changes during busy SHALL have no effect.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE.
REQ-025 start held high continuously SHALL launch back-to-back divisions, each reloading operands in IDLE.

Reset
REQ-026 clear=1 SHALL immediately force IDLE, busy=0, done=0, div_by_zero=0, c_quotient_and_remainder=0, iteration counter=0, independent of clock.
REQ-027 clear asserted mid-division SHALL abort it with no done pulse; first start after clear release SHALL behave as from power-up.

Verification (WIDTH=32 unless noted)
REQ-028 Unsigned 100/7 -> quotient 0x0000000E, remainder 0x00000002, done 34 cycles after start, div_by_zero=0.
REQ-029 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; same operands unsigned -> quotient 0x7FFFFFFC, remainder 0x00000001.
REQ-030 5/0 either mode -> quotient 0xFFFFFFFF, remainder 0x00000005, div_by_zero=1, done 2 cycles after start.
REQ-031 Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
REQ-032 Start 100/7, pulse start with 9/3 at cycle 10, pulse clear at cycle 20 -> no done, all outputs 0; subsequent 9/3 -> quotient 3, remainder 0.
REQ-033 WIDTH=8, random signed/unsigned operands vs. reference model -> exact match, done 10 cycles after start.

Source files
------------

// File: rtl/div_seq_n.sv
// div_seq_n: sequential divider, one non-restoring iteration per clock.
// Supports unsigned and two's-complement (truncating) division.
//
// Ports
//   clock                     sole clock, rising edge
//   clear                     asynchronous active-high reset
//   start                     request, sampled only in IDLE
//   signed_mode               1 = signed divide, sampled with start
//   a_dividend, b_divisor     operands, sampled with start
//   busy                      high in CALC and FIX
//   done                      one-cycle pulse in DONE
//   div_by_zero               set with the result when the divisor was 0
//   c_quotient_and_remainder  {remainder, quotient}, held until the next FIX
//
// state | meaning
// IDLE  | waiting for start; operands latched on the accepting edge
// CALC  | WIDTH non-restoring iterations on |a| / |b|
// FIX   | final remainder restore, sign fix-up, result registered
// DONE  | done pulse, busy low; back to IDLE on the next edge
module div_seq_n #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a_dividend,
  input  logic [WIDTH-1:0]   b_divisor,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] c_quotient_and_remainder
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH:0]   acc;       // partial remainder A, WIDTH+1 bits, signed
  logic [WIDTH-1:0] quo;       // Q register: dividend magnitude shifts out, quotient bits shift in
  logic [WIDTH-1:0] dsr;       // divisor magnitude
  logic [WIDTH-1:0] dvd_raw;   // untouched dividend, returned as remainder on divide-by-zero
  logic             neg_q;
  logic             neg_r;
  logic             zero_div;
  logic [CW-1:0]    cnt;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, acc_step, rem_fix;
  logic [WIDTH-1:0] quo_step, rem_mag, q_out, r_out;

  // operand magnitudes; the most negative value maps to itself, which is
  // the correct unsigned magnitude
  always_comb begin
    a_neg = signed_mode & a_dividend[WIDTH-1];
    b_neg = signed_mode & b_divisor[WIDTH-1];
    a_mag = a_neg ? (~a_dividend + 1'b1) : a_dividend;
    b_mag = b_neg ? (~b_divisor + 1'b1) : b_divisor;
  end

  // one non-restoring step: shift {A,Q}, then subtract when A was
  // non-negative, add when it was negative; new quotient bit = ~sign(A)
  always_comb begin
    shifted  = {acc[WIDTH-1:0], quo[WIDTH-1]};
    acc_step = acc[WIDTH] ? (shifted + {1'b0, dsr}) : (shifted - {1'b0, dsr});
    quo_step = {quo[WIDTH-2:0], ~acc_step[WIDTH]};
  end

  always_comb begin
    rem_fix = acc[WIDTH] ? (acc + {1'b0, dsr}) : acc;
    rem_mag = rem_fix[WIDTH-1:0];
    q_out   = neg_q ? (~quo + 1'b1) : quo;
    r_out   = neg_r ? (~rem_mag + 1'b1) : rem_mag;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = (b_divisor == '0) ? FIX : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_nx = FIX;
      end
      FIX: begin
        busy     = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      acc                      <= '0;
      quo                      <= '0;
      dsr                      <= '0;
      dvd_raw                  <= '0;
      neg_q                    <= 1'b0;
      neg_r                    <= 1'b0;
      zero_div                 <= 1'b0;
      cnt                      <= '0;
      div_by_zero              <= 1'b0;
      c_quotient_and_remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            quo      <= a_mag;
            dsr      <= b_mag;
            dvd_raw  <= a_dividend;
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            zero_div <= (b_divisor == '0);
            cnt      <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          acc <= acc_step;
          quo <= quo_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          div_by_zero <= zero_div;
          if (zero_div) c_quotient_and_remainder <= {dvd_raw, {WIDTH{1'b1}}};
          else          c_quotient_and_remainder <= {r_out, q_out};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_n.sv
// tb_div_seq_n: scoreboard bench for div_seq_n at WIDTH=32 and WIDTH=8.
module tb_div_seq_n;

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    int          t0;
    int          lat;
  } exp_t;

  logic        clock, clear;
  logic        start32, sm32, busy32, done32, dbz32;
  logic [31:0] a32, b32;
  logic [63:0] res32;
  logic        start8, sm8, busy8, done8, dbz8;
  logic [7:0]  a8, b8;
  logic [15:0] res8;

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  logic [63:0] last32 = '0;
  exp_t q32[$];
  exp_t q8[$];

  div_seq_n #(.WIDTH(32)) u_dut32 (
    .clock(clock), .clear(clear), .start(start32), .signed_mode(sm32),
    .a_dividend(a32), .b_divisor(b32), .busy(busy32), .done(done32),
    .div_by_zero(dbz32), .c_quotient_and_remainder(res32)
  );

  div_seq_n #(.WIDTH(8)) u_dut8 (
    .clock(clock), .clear(clear), .start(start8), .signed_mode(sm8),
    .a_dividend(a8), .b_divisor(b8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .c_quotient_and_remainder(res8)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // truncating-division reference: packs {remainder, quotient} for w bits
  function automatic logic [63:0] ref_div(input int w, input logic sm,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    if ((b & mask) == 64'd0) return ((a & mask) << w) | mask;
    if (sm) begin
      sa = $signed(a << (64 - w)) >>> (64 - w);
      sb = $signed(b << (64 - w)) >>> (64 - w);
    end else begin
      sa = longint'(a & mask);
      sb = longint'(b & mask);
    end
    q = sa / sb;
    r = sa % sb;
    return ((64'(r) & mask) << w) | (64'(q) & mask);
  endfunction

  always @(negedge clock) begin : mon32
    exp_t e;
    if (done32) begin
      if (q32.size() == 0) chk("unexpected_done32", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        chk("res32", res32, e.res);
        chk("dbz32", 64'(dbz32), 64'(e.dbz));
        chk("lat32", 64'(cyc - e.t0 + 1), 64'(e.lat));
        chk("busy_done32", 64'(busy32), 64'd0);
        last32 = e.res;
      end
    end
  end

  always @(negedge clock) begin : mon8
    exp_t e;
    if (done8) begin
      if (q8.size() == 0) chk("unexpected_done8", 64'd1, 64'd0);
      else begin
        e = q8.pop_front();
        chk("res8", 64'(res8), e.res);
        chk("dbz8", 64'(dbz8), 64'(e.dbz));
        chk("lat8", 64'(cyc - e.t0 + 1), 64'(e.lat));
      end
    end
  end

  task automatic drain32();
    for (int i = 0; i < 200 && q32.size() != 0; i++) @(negedge clock);
    if (q32.size() != 0) begin
      chk("timeout32", 64'(q32.size()), 64'd0);
      q32.delete();
    end
  endtask

  task automatic drain8();
    for (int i = 0; i < 200 && q8.size() != 0; i++) @(negedge clock);
    if (q8.size() != 0) begin
      chk("timeout8", 64'(q8.size()), 64'd0);
      q8.delete();
    end
  endtask

  task automatic push32(input logic [63:0] res, input logic dbz, input int t0);
    exp_t e;
    e.res = res; e.dbz = dbz; e.t0 = t0; e.lat = dbz ? 2 : 34;
    q32.push_back(e);
  endtask

  task automatic drive32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input logic dbz);
    @(negedge clock);
    sm32 = sm; a32 = a; b32 = b; start32 = 1'b1;
    push32(res, dbz, cyc + 1);
    @(negedge clock);
    start32 = 1'b0;
    chk("busy32", 64'(busy32), 64'd1);
    drain32();
  endtask

  task automatic drive8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    @(negedge clock);
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    e.res = ref_div(8, sm, 64'(a), 64'(b));
    e.dbz = (b == 8'd0);
    e.t0  = cyc + 1;
    e.lat = e.dbz ? 2 : 10;
    q8.push_back(e);
    @(negedge clock);
    start8 = 1'b0;
    drain8();
  endtask

  task automatic wait_done32(input string tag);
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (done32) break;
    end
    if (!done32) chk(tag, 64'd0, 64'd1);
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clear = 1'b1;
    start32 = 1'b0; sm32 = 1'b0; a32 = '0; b32 = '0;
    start8  = 1'b0; sm8  = 1'b0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clock);
    chk("rst_busy32", 64'(busy32), 64'd0);
    chk("rst_done32", 64'(done32), 64'd0);
    chk("rst_dbz32",  64'(dbz32),  64'd0);
    chk("rst_res32",  res32,       64'd0);
    chk("rst_busy8",  64'(busy8),  64'd0);
    chk("rst_res8",   64'(res8),   64'd0);
    clear = 1'b0;

    drive32(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
    drive32(1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    drive32(1'b0, 32'hFFFFFFF9, 32'd2, {32'd1, 32'h7FFFFFFC}, 1'b0);
    drive32(1'b1, 32'd7, 32'hFFFFFFFE, {32'd1, 32'hFFFFFFFD}, 1'b0);
    drive32(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, {32'hFFFFFFFF, 32'd3}, 1'b0);
    drive32(1'b0, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b1);
    drive32(1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b1);
    drive32(1'b1, 32'hFFFFFFFB, 32'd0, {32'hFFFFFFFB, 32'hFFFFFFFF}, 1'b1);
    drive32(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0);
    drive32(1'b0, 32'hFFFFFFFF, 32'd1, {32'd0, 32'hFFFFFFFF}, 1'b0);

    // start and operand noise while busy, then a start pulse during DONE
    @(negedge clock);
    sm32 = 1'b0; a32 = 32'd1000; b32 = 32'd33; start32 = 1'b1;
    push32({32'd10, 32'd30}, 1'b0, cyc + 1);
    @(negedge clock);
    start32 = 1'b0;
    repeat (4) @(negedge clock);
    sm32 = 1'b1; a32 = 32'd0; b32 = 32'd0; start32 = 1'b1;
    repeat (3) @(negedge clock);
    start32 = 1'b0;
    wait_done32("noise_timeout32");
    a32 = 32'd5; b32 = 32'd0; start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    repeat (50) @(negedge clock);
    chk("done_start_ignored32", 64'(busy32), 64'd0);
    drain32();

    // start held high: two back-to-back divisions, operands reloaded in IDLE
    @(negedge clock);
    sm32 = 1'b0; a32 = 32'd50; b32 = 32'd6; start32 = 1'b1;
    push32({32'd2, 32'd8}, 1'b0, cyc + 1);
    wait_done32("b2b1_timeout32");
    sm32 = 1'b1; a32 = 32'hFFFFFFCE; b32 = 32'd6;
    push32({32'hFFFFFFFE, 32'hFFFFFFF8}, 1'b0, cyc + 2);
    @(negedge clock);
    wait_done32("b2b2_timeout32");
    start32 = 1'b0;
    drain32();

    // abort mid-division with clear
    @(negedge clock);
    sm32 = 1'b0; a32 = 32'd100; b32 = 32'd7; start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    repeat (8) @(negedge clock);
    a32 = 32'd9; b32 = 32'd3; start32 = 1'b1;
    chk("hold_calc32", res32, last32);
    chk("busy_calc32", 64'(busy32), 64'd1);
    @(negedge clock);
    start32 = 1'b0;
    repeat (9) @(negedge clock);
    #1 clear = 1'b1;
    #1;
    chk("clr_busy32", 64'(busy32), 64'd0);
    chk("clr_done32", 64'(done32), 64'd0);
    chk("clr_dbz32",  64'(dbz32),  64'd0);
    chk("clr_res32",  res32,       64'd0);
    @(negedge clock);
    clear = 1'b0;
    repeat (40) @(negedge clock);
    chk("post_clr_busy32", 64'(busy32), 64'd0);
    drive32(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    // WIDTH=8 against the reference model
    drive8(1'b1, 8'h80, 8'hFF);
    drive8(1'b1, 8'hF9, 8'h00);
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      drive8(1'($urandom_range(0, 1)), ra, rb);
    end

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
